ext_mem_arbiter: RTL and testbench

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

---
 rtl/ext_mem_arbiter_if.sv | 49 ++++
 rtl/ext_mem_arbiter.sv | 94 +++++++++
 tb/tb_ext_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_arbiter_if.sv
// Bus bundle between I/D-cache requesters, the arbiter and external memory.
// slave: arbiter view; master: requester/memory view.
interface ext_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              req0_cs;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data_i;
  logic [DATA_W-1:0] req0_data_o;
  logic              req0_ack;

  logic              req1_cs;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data_i;
  logic [DATA_W-1:0] req1_data_o;
  logic              req1_ack;

  logic              ext_mem_cs;
  logic              ext_mem_we;
  logic [ADDR_W-1:0] ext_mem_addr;
  logic [DATA_W-1:0] ext_mem_data_o;
  logic [DATA_W-1:0] ext_mem_data_i;
  logic              ext_mem_ack;

  logic [1:0]        grant;

  modport slave (
    input  req0_cs, req0_we, req0_addr, req0_data_i,
    output req0_data_o, req0_ack,
    input  req1_cs, req1_we, req1_addr, req1_data_i,
    output req1_data_o, req1_ack,
    output ext_mem_cs, ext_mem_we, ext_mem_addr, ext_mem_data_o,
    input  ext_mem_data_i, ext_mem_ack,
    output grant
  );

  modport master (
    output req0_cs, req0_we, req0_addr, req0_data_i,
    input  req0_data_o, req0_ack,
    output req1_cs, req1_we, req1_addr, req1_data_i,
    input  req1_data_o, req1_ack,
    input  ext_mem_cs, ext_mem_we, ext_mem_addr, ext_mem_data_o,
    output ext_mem_data_i, ext_mem_ack,
    input  grant
  );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Two-port (I$=0, D$=1) external memory arbiter, alternating on ties.
// Ports: clk, rst (async active-low), bus (ext_mem_arbiter_if.slave).
module ext_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input logic               clk,
  input logic               rst,
  ext_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last;
  logic              last_nx;
  logic              cap;
  logic              cap_sel;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cap      = 1'b0;
    cap_sel  = 1'b0;
    unique case (state)
      IDLE: begin
        // port 0 wins unless it also won the previous tie
        if (bus.req0_cs && (!bus.req1_cs || last)) begin
          state_nx = SERVE0;
          cap      = 1'b1;
        end else if (bus.req1_cs) begin
          state_nx = SERVE1;
          cap      = 1'b1;
          cap_sel  = 1'b1;
        end
      end
      SERVE0: begin
        if (bus.ext_mem_ack) begin
          state_nx = RELEASE;
          last_nx  = 1'b0;
        end
      end
      SERVE1: begin
        if (bus.ext_mem_ack) begin
          state_nx = RELEASE;
          last_nx  = 1'b1;
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      addr_q <= '0;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      if (cap) begin
        addr_q <= cap_sel ? bus.req1_addr   : bus.req0_addr;
        we_q   <= cap_sel ? bus.req1_we     : bus.req0_we;
        data_q <= cap_sel ? bus.req1_data_i : bus.req0_data_i;
      end
    end
  end

  assign bus.grant          = {state == SERVE1, state == SERVE0};
  assign bus.ext_mem_cs     = |bus.grant;
  assign bus.ext_mem_addr   = addr_q;
  assign bus.ext_mem_we     = we_q;
  assign bus.ext_mem_data_o = data_q;

  // an abandoned request (cs dropped) swallows its ack
  assign bus.req0_ack = bus.ext_mem_ack & bus.grant[0] & bus.req0_cs;
  assign bus.req1_ack = bus.ext_mem_ack & bus.grant[1] & bus.req1_cs;

  assign bus.req0_data_o = bus.req0_ack ? bus.ext_mem_data_i : '0;
  assign bus.req1_data_o = bus.req1_ack ? bus.ext_mem_data_i : '0;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed scoreboard bench for ext_mem_arbiter.
// Expected transactions are queued at request time, checked at grant/ack.
module tb_ext_mem_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic        we;
    logic [255:0] wdata;
    logic [255:0] rdata;
    bit          acked;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  ext_mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus ();

  ext_mem_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit p, input logic [31:0] a, input logic w,
                     input logic [255:0] wd, input logic [255:0] rd,
                     input bit acked);
    exp_t e;
    e.port  = p;
    e.addr  = a;
    e.we    = w;
    e.wdata = wd;
    e.rdata = rd;
    e.acked = acked;
    sb.push_back(e);
    if (p) begin
      bus.req1_cs     = 1'b1;
      bus.req1_addr   = a;
      bus.req1_we     = w;
      bus.req1_data_i = wd;
    end else begin
      bus.req0_cs     = 1'b1;
      bus.req0_addr   = a;
      bus.req0_we     = w;
      bus.req0_data_i = wd;
    end
  endtask

  task automatic wait_cs(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.ext_mem_cs) break;
      @(negedge clk);
    end
    chk("cs_wait", 256'(bus.ext_mem_cs), 256'(1'b1));
  endtask

  // Called at a negedge where ext_mem_cs is expected high.
  task automatic serve(input int lat, input bit mutate,
                       input int drop_at, input bit keep);
    exp_t e;
    chk("sb_has_entry", 256'(sb.size() != 0), 256'(1'b1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant", 256'(bus.grant), 256'(e.port ? 2'b10 : 2'b01));
    chk("mem_cs", 256'(bus.ext_mem_cs), 256'(1'b1));
    chk("mem_addr", 256'(bus.ext_mem_addr), 256'(e.addr));
    chk("mem_we", 256'(bus.ext_mem_we), 256'(e.we));
    chk("mem_wdata", bus.ext_mem_data_o, e.wdata);
    for (int i = 0; i < lat; i++) begin
      if (mutate && i == 1) begin
        if (e.port) begin
          bus.req1_addr   = ~e.addr;
          bus.req1_we     = ~e.we;
          bus.req1_data_i = ~e.wdata;
        end else begin
          bus.req0_addr   = ~e.addr;
          bus.req0_we     = ~e.we;
          bus.req0_data_i = ~e.wdata;
        end
      end
      if (i == drop_at) begin
        if (e.port) bus.req1_cs = 1'b0;
        else bus.req0_cs = 1'b0;
      end
      @(negedge clk);
      chk("hold_cs", 256'(bus.ext_mem_cs), 256'(1'b1));
      chk("hold_addr", 256'(bus.ext_mem_addr), 256'(e.addr));
      chk("hold_we", 256'(bus.ext_mem_we), 256'(e.we));
      chk("hold_data", bus.ext_mem_data_o, e.wdata);
      chk("no_early_ack", 256'({bus.req1_ack, bus.req0_ack}), 256'(2'b00));
    end
    bus.ext_mem_data_i = e.rdata;
    bus.ext_mem_ack    = 1'b1;
    #1;
    chk("ack0", 256'(bus.req0_ack), 256'(e.acked && !e.port));
    chk("ack1", 256'(bus.req1_ack), 256'(e.acked && e.port));
    chk("data0", bus.req0_data_o, (e.acked && !e.port) ? e.rdata : 256'd0);
    chk("data1", bus.req1_data_o, (e.acked && e.port) ? e.rdata : 256'd0);
    @(negedge clk);
    bus.ext_mem_ack    = 1'b0;
    bus.ext_mem_data_i = {8{32'hDEAD_BEEF}};
    if (!keep) begin
      if (e.port) bus.req1_cs = 1'b0;
      else bus.req0_cs = 1'b0;
    end
    chk("release_cs", 256'(bus.ext_mem_cs), 256'(1'b0));
    chk("release_grant", 256'(bus.grant), 256'(2'b00));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cs"}, 256'(bus.ext_mem_cs), 256'(1'b0));
    chk({tag, "_we"}, 256'(bus.ext_mem_we), 256'(1'b0));
    chk({tag, "_addr"}, 256'(bus.ext_mem_addr), 256'd0);
    chk({tag, "_wdata"}, bus.ext_mem_data_o, 256'd0);
    chk({tag, "_grant"}, 256'(bus.grant), 256'(2'b00));
    chk({tag, "_acks"}, 256'({bus.req1_ack, bus.req0_ack}), 256'(2'b00));
    chk({tag, "_d0"}, bus.req0_data_o, 256'd0);
    chk({tag, "_d1"}, bus.req1_data_o, 256'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req0_cs = 1'b0; bus.req0_we = 1'b0;
    bus.req0_addr = '0; bus.req0_data_i = '0;
    bus.req1_cs = 1'b0; bus.req1_we = 1'b0;
    bus.req1_addr = '0; bus.req1_data_i = '0;
    bus.ext_mem_ack = 1'b0;
    bus.ext_mem_data_i = '0;
    #2 rst = 1'b0;
    #10;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // single fill on port 0, ack 10 cycles later
    @(negedge clk);
    req(1'b0, 32'h40, 1'b0, {8{32'h0BAD_F00D}}, {32{8'hA5}}, 1'b1);
    @(negedge clk);
    chk("fill_latency", 256'(bus.ext_mem_cs), 256'(1'b1));
    serve(10, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("fill_idle_grant", 256'(bus.grant), 256'(2'b00));

    // simultaneous requests right after reset: port 0 then port 1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req(1'b0, 32'h80, 1'b0, 256'h11, 256'hAAAA, 1'b1);
    req(1'b1, 32'h200, 1'b0, 256'h22, 256'hBBBB, 1'b1);
    @(negedge clk);
    serve(3, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("gap_idle_grant", 256'(bus.grant), 256'(2'b00));
    @(negedge clk);
    chk("p1_after_gap", 256'(bus.grant), 256'(2'b10));
    serve(4, 1'b0, -1, 1'b0);

    // both ports continuously requesting: 01,10,01,10
    @(negedge clk);
    req(1'b0, 32'h1000, 1'b0, 256'h33, 256'hC0, 1'b1);
    req(1'b1, 32'h2000, 1'b1, 256'h44, 256'hC1, 1'b1);
    req(1'b0, 32'h1000, 1'b0, 256'h33, 256'hC2, 1'b1);
    req(1'b1, 32'h2000, 1'b1, 256'h44, 256'hC3, 1'b1);
    for (int t = 0; t < 4; t++) begin
      wait_cs(6);
      serve(2, 1'b0, -1, t < 3);
    end
    bus.req0_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("alt_done_idle", 256'(bus.ext_mem_cs), 256'(1'b0));

    // write-back with requester inputs changing mid-transaction
    req(1'b1, 32'h100, 1'b1, 256'h1234, 256'h5555, 1'b1);
    @(negedge clk);
    serve(6, 1'b1, -1, 1'b0);
    @(negedge clk);

    // port 0 abandons its request 3 cycles into service
    req(1'b0, 32'h300, 1'b0, 256'h77, 256'h9999, 1'b0);
    @(negedge clk);
    serve(8, 1'b0, 3, 1'b0);
    @(negedge clk);
    chk("drop_idle_grant", 256'(bus.grant), 256'(2'b00));
    chk("drop_idle_cs", 256'(bus.ext_mem_cs), 256'(1'b0));
    @(negedge clk);
    chk("drop_stays_idle", 256'(bus.ext_mem_cs), 256'(1'b0));

    // reset during SERVE1, then a stale ack
    bus.req1_cs     = 1'b1;
    bus.req1_we     = 1'b1;
    bus.req1_addr   = 32'h500;
    bus.req1_data_i = 256'hFEED;
    @(negedge clk);
    chk("rst_test_grant", 256'(bus.grant), 256'(2'b10));
    chk("rst_test_addr", 256'(bus.ext_mem_addr), 256'(32'h500));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req1_cs = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    bus.ext_mem_data_i = {8{32'hCAFE_0001}};
    bus.ext_mem_ack = 1'b1;
    #1;
    chk("late_ack0", 256'(bus.req0_ack), 256'(1'b0));
    chk("late_ack1", 256'(bus.req1_ack), 256'(1'b0));
    chk("late_data1", bus.req1_data_o, 256'd0);
    @(negedge clk);
    bus.ext_mem_ack = 1'b0;
    chk("late_ack_grant", 256'(bus.grant), 256'(2'b00));
    chk("late_ack_cs", 256'(bus.ext_mem_cs), 256'(1'b0));

    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
